// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants for the FIFO read-side packer.
// The optional idle-flush feature is enabled by defining FIFO_RD_PACKER_FLUSH_EN.
package fifo_rd_packer_pkg;

  localparam int LANES_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 16;

endpackage : fifo_rd_packer_pkg

// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the CDC FIFO read port, the packer and the wide-word consumer.
// slave is the packer side; master is the environment (FIFO + consumer) side.
interface fifo_rd_packer_if
  import fifo_rd_packer_pkg::*;
#(
  parameter int EW    = 8,
  parameter int LANES = LANES_DEF
);

  logic [EW-1:0]       in_data;
  logic                in_rdy;
  logic                in_get;
  logic [LANES*EW-1:0] out_data;
  logic [LANES-1:0]    out_keep;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_data,
    input  in_rdy,
    output in_get,
    output out_data,
    output out_keep,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_rdy,
    input  in_get,
    input  out_data,
    input  out_keep,
    input  out_valid,
    output out_ready
  );

endinterface : fifo_rd_packer_if

// File: rtl/pack_out_reg.sv
// Single-entry valid/ready holding register for the packed word and its keep mask.
// free_o tells the producer a load on the coming edge will not overwrite an unaccepted word.
module pack_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // A word that transfers this cycle frees the slot for a same-edge reload.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule : pack_out_reg

// File: rtl/fifo_rd_packer.sv
// Pops entries from the CDC FIFO read port and packs LANES of them into one wide word.
// Define FIFO_RD_PACKER_FLUSH_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter type dat_t   = logic [7:0],
  parameter int  LANES   = LANES_DEF,
  parameter int  TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_rd_packer_if.slave  bus
);

  localparam int EW     = $bits(dat_t);
  localparam int IDX_W  = $clog2(LANES);
  localparam int WORD_W = LANES * EW;

  typedef logic [LANES-1:0] keep_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_LANE = idx_t'(LANES - 1);

  if (LANES < 2 || LANES > 16) begin : g_bad_lanes
    $error("fifo_rd_packer: LANES must be within 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT must be within 1..65535");
  end

  dat_t              entry;
  idx_t              idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              last_lane;
  logic              accept;
  logic              out_free;
  logic              load;
  logic [WORD_W-1:0] load_word;
  keep_t             load_keep;
  logic [WORD_W+LANES-1:0] out_payload;

  assign entry     = dat_t'(bus.in_data);
  assign last_lane = (idx_q == LAST_LANE);

  // Only a lane-completing pop can be blocked, and only by an unaccepted word.
  assign bus.in_get = rst_n && bus.in_rdy && !(last_lane && !out_free);
  assign accept     = bus.in_get;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_due;

  // Accept has priority; the else-if below keeps a racing flush from firing.
  assign flush_due = (idx_q != '0) && (cnt_q == TMO) && out_free;

  always_comb begin
    cnt_d = cnt_q;
    if (accept || flush_due) begin
      cnt_d = '0;
    end else if (idx_q != '0 && cnt_q != TMO) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    asm_d     = asm_q;
    idx_d     = idx_q;
    load      = 1'b0;
    load_word = '0;
    load_keep = '0;
    if (accept) begin
      asm_d[idx_q*EW +: EW] = entry;
      if (last_lane) begin
        load      = 1'b1;
        load_word = asm_d;
        load_keep = '1;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
`ifdef FIFO_RD_PACKER_FLUSH_EN
    else if (flush_due) begin
      load  = 1'b1;
      idx_d = '0;
      for (int i = 0; i < LANES; i++) begin
        if (idx_t'(i) < idx_q) begin
          load_word[i*EW +: EW] = asm_q[i*EW +: EW];
          load_keep[i]          = 1'b1;
        end
      end
    end
`endif
  end

  // Stale lanes beyond idx are never exposed, but reset keeps the assembly state deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  pack_out_reg #(
    .W (WORD_W + LANES)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .data_i  ({load_keep, load_word}),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (out_payload),
    .free_o  (out_free)
  );

  assign {bus.out_keep, bus.out_data} = out_payload;

endmodule : fifo_rd_packer
